// File: rtl/out_signature_misr.sv
// Multiple-input signature register that compacts the fuzz DUT's out_flat word
// over a programmed number of accepted samples and compares the result with a golden value.
module out_signature_misr #(
  parameter int              DATA_W = 330,
  parameter int              SIG_W  = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF,
  parameter int              CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_cycles,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count,
  output logic              pass
);

  localparam int N_CHUNKS = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W    = N_CHUNKS * SIG_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // XOR of all zero-padded SIG_W-wide chunks of the input word.
  function automatic logic [SIG_W-1:0] fold_word(input logic [DATA_W-1:0] d);
    logic [PAD_W-1:0] padded;
    logic [SIG_W-1:0] acc;
    padded = {PAD_W{1'b0}};
    padded[DATA_W-1:0] = d;
    acc = {SIG_W{1'b0}};
    for (int k = 0; k < N_CHUNKS; k++) begin
      acc = acc ^ padded[k*SIG_W +: SIG_W];
    end
    return acc;
  endfunction

  // One MISR shift: Galois feedback on the outgoing MSB, then fold injection.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] fold);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ fold;
  endfunction

  logic [1:0]       state_r;
  logic [SIG_W-1:0] sig_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] target_r;
  logic             busy_r;
  logic             done_r;

  logic [1:0]       state_nxt_s;
  logic [SIG_W-1:0] sig_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] target_nxt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [SIG_W-1:0] fold_s;

  assign cnt_inc_s = cnt_r + CNT_ONE;
  assign fold_s    = fold_word(in_data);

  // Next-state and datapath selection for the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt_s  = state_r;
    sig_nxt_s    = sig_r;
    cnt_nxt_s    = cnt_r;
    target_nxt_s = target_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sig_nxt_s    = SEED;
          cnt_nxt_s    = CNT_ZERO;
          target_nxt_s = num_cycles;
          if (num_cycles == CNT_ZERO) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          sig_nxt_s = misr_step(sig_r, fold_s);
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == target_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      sig_r    <= SEED;
      cnt_r    <= CNT_ZERO;
      target_r <= CNT_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      sig_r    <= sig_nxt_s;
      cnt_r    <= cnt_nxt_s;
      target_r <= target_nxt_s;
      busy_r   <= (state_nxt_s == ST_RUN);
      done_r   <= (state_nxt_s == ST_DONE);
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign signature    = sig_r;
  assign sample_count = cnt_r;
  assign pass         = done_r && (sig_r == expected_sig);

endmodule

// File: tb/tb_out_signature_misr.sv
// Randomized self-checking bench for out_signature_misr against a bit-level behavioural model.
module tb_out_signature_misr;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  num_cycles;
  logic         in_valid;
  logic [329:0] in_data;
  logic [31:0]  expected_sig;
  logic         busy;
  logic         done;
  logic [31:0]  signature;
  logic [31:0]  sample_count;
  logic         pass;

  out_signature_misr dut (
    .clk(clk), .rst(rst), .start(start), .num_cycles(num_cycles),
    .in_valid(in_valid), .in_data(in_data), .expected_sig(expected_sig),
    .busy(busy), .done(done), .signature(signature),
    .sample_count(sample_count), .pass(pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic        m_run, m_done;
  logic [31:0] m_sig, m_cnt, m_tgt;
  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] ref_fold(input logic [329:0] d);
    logic [31:0] f;
    f = 32'd0;
    for (int i = 0; i < 330; i++) f[i % 32] = f[i % 32] ^ d[i];
    return f;
  endfunction

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] f);
    logic [32:0] wide;
    wide = {s, 1'b0};
    if (wide[32]) wide[31:0] = wide[31:0] ^ POLY;
    return wide[31:0] ^ f;
  endfunction

  function automatic logic [329:0] rand_data();
    logic [351:0] t;
    for (int k = 0; k < 11; k++) t[k*32 +: 32] = $urandom;
    return t[329:0];
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_sig = SEED; m_cnt = 32'd0; m_tgt = 32'd0;
  endtask

  task automatic model_edge();
    if (!m_run && start) begin
      m_sig = SEED; m_cnt = 32'd0; m_tgt = num_cycles;
      m_run = (num_cycles != 32'd0);
      m_done = (num_cycles == 32'd0);
    end else if (m_run && in_valid) begin
      m_sig = ref_step(m_sig, ref_fold(in_data));
      m_cnt = m_cnt + 32'd1;
      if (m_cnt == m_tgt) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      nvec++;
      if (busy !== m_run || done !== m_done || signature !== m_sig ||
          sample_count !== m_cnt || pass !== (m_done && m_sig == expected_sig)) begin
        nerr++;
        $display("FAIL cycle: got busy=%b done=%b sig=%h cnt=%0d pass=%b expected busy=%b done=%b sig=%h cnt=%0d pass=%b at %0t",
                 busy, done, signature, sample_count, pass, m_run, m_done, m_sig, m_cnt,
                 (m_done && m_sig == expected_sig), $time);
      end
    end
  end

  task automatic pulse_start(input logic [31:0] n);
    start = 1'b1; num_cycles = n;
    tick();
    start = 1'b0;
  endtask

  task automatic run_random(input int bound);
    int c;
    c = 0;
    while (!m_done && c < bound) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = rand_data();
      start    = ($urandom_range(0, 9) == 0);
      num_cycles = $urandom_range(0, 50);
      tick();
      c++;
    end
    start = 1'b0;
    if (!m_done) check_lit("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_cycles = 32'd0; in_valid = 1'b0;
    in_data = '0; expected_sig = 32'd0;
    model_reset();
    chk_en = 1'b1;
    tick(); tick();
    check_lit("reset_sig", signature, 32'hFFFFFFFF);
    check_lit("reset_flags", {28'd0, busy, done, pass, 1'b0}, 32'd0);
    check_lit("reset_cnt", sample_count, 32'd0);
    rst = 1'b0;
    tick();

    // zero-length run
    pulse_start(32'd0);
    check_lit("n0_done", {31'd0, done}, 32'd1);
    check_lit("n0_sig", signature, 32'hFFFFFFFF);
    check_lit("n0_cnt", sample_count, 32'd0);
    tick();

    // single zero sample
    in_valid = 1'b1; in_data = '0;
    pulse_start(32'd1);
    tick();
    in_valid = 1'b0;
    check_lit("n1_sig", signature, 32'hFB3EE249);
    check_lit("n1_done", {31'd0, done}, 32'd1);
    expected_sig = 32'hFB3EE249; #1;
    check_lit("pass_hi", {31'd0, pass}, 32'd1);
    expected_sig = 32'd0; #1;
    check_lit("pass_lo", {31'd0, pass}, 32'd0);

    // chunk 0 and chunk 10 fold
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_data = '0;
      in_data[b == 0 ? 0 : 320] = 1'b1;
      pulse_start(32'd1);
      tick();
      in_valid = 1'b0;
      check_lit(b == 0 ? "bit0_sig" : "bit320_sig", signature, 32'hFB3EE248);
    end

    // gapped run with ignored mid-run start
    in_data = '0; in_valid = 1'b0;
    pulse_start(32'd3);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 0 || i == 3 || i == 4);
      start = (i == 2); num_cycles = 32'd7;
      tick();
      if (i == 3) check_lit("gap_notdone", {31'd0, done}, 32'd0);
    end
    start = 1'b0; in_valid = 1'b0;
    check_lit("gap_done", {31'd0, done}, 32'd1);
    check_lit("gap_cnt", sample_count, 32'd3);
    check_lit("gap_sig", signature, 32'hE1B8AFFD);

    // reset mid-run
    pulse_start(32'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin in_data = rand_data(); tick(); end
    in_valid = 1'b0;
    #2 rst = 1'b1; model_reset(); #1;
    check_lit("arst_sig", signature, 32'hFFFFFFFF);
    check_lit("arst_cnt", sample_count, 32'd0);
    check_lit("arst_flags", {30'd0, busy, done}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    tick();
    pulse_start(32'($urandom_range(4, 8)));
    run_random(300);

    // frozen in DONE, then restart with 2
    for (int i = 0; i < 10; i++) begin
      in_valid = $urandom_range(0, 1); in_data = rand_data(); tick();
    end
    pulse_start(32'd2);
    run_random(300);

    // random runs
    for (int r = 0; r < 30; r++) begin
      pulse_start(32'($urandom_range(1, 20)));
      run_random(500);
      expected_sig = ($urandom_range(0, 1) == 1) ? m_sig : 32'($urandom);
      tick(); tick();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
